// File: rtl/cv32e40p_alu_retry_ctrl_if.sv
// rtl/cv32e40p_alu_retry_ctrl_if.sv - issue, ALU, response and fault-status signals of the ALU retry controller
interface cv32e40p_alu_retry_ctrl_if #(
  parameter int CNT_W = 8
);
  // EX-stage request
  logic             req_valid_i;
  logic             req_ready_o;
  // Hardened ALU
  logic             alu_enable_o;
  logic             alu_ready_i;
  logic             alu_fault_i;
  logic [31:0]      alu_result_i;
  logic             alu_cmp_i;
  // Response back to EX
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic             rsp_cmp_o;
  logic             rsp_error_o;
  // Fault bookkeeping
  logic             clr_cnt_i;
  logic [CNT_W-1:0] fault_cnt_o;
  logic             fault_irq_o;
  logic             perm_fault_o;

  // Controller side
  modport slave (
    input  req_valid_i, alu_ready_i, alu_fault_i, alu_result_i, alu_cmp_i,
           rsp_ready_i, clr_cnt_i,
    output req_ready_o, alu_enable_o, rsp_valid_o, rsp_result_o, rsp_cmp_o,
           rsp_error_o, fault_cnt_o, fault_irq_o, perm_fault_o
  );

  // EX stage plus ALU side (environment)
  modport master (
    output req_valid_i, alu_ready_i, alu_fault_i, alu_result_i, alu_cmp_i,
           rsp_ready_i, clr_cnt_i,
    input  req_ready_o, alu_enable_o, rsp_valid_o, rsp_result_o, rsp_cmp_o,
           rsp_error_o, fault_cnt_o, fault_irq_o, perm_fault_o
  );
endinterface

// File: rtl/cv32e40p_alu_retry_ctrl.sv
// rtl/cv32e40p_alu_retry_ctrl.sv - retry sequencer between EX issue and the TMR-hardened ALU
module cv32e40p_alu_retry_ctrl #(
  parameter int MAX_RETRY  = 2,
  parameter int CNT_W      = 8,
  parameter int IRQ_THRESH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  cv32e40p_alu_retry_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] RETRY = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [2:0]       MAX_R   = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] IRQ_VAL = CNT_W'(IRQ_THRESH);

  logic [1:0]       state_q, state_d;
  logic [2:0]       retry_q;
  logic [31:0]      result_q;
  logic             cmp_q;
  logic             error_q;
  logic             perm_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q;

  logic sample;     // ALU result is taken this cycle
  logic inc;        // the taken result carries a voter fault
  logic exhausted;  // faulty sample with no replay budget left
  logic retire;     // EX accepts the response this cycle

  assign sample    = (state_q == EXEC) && bus.alu_ready_i;
  assign inc       = sample && bus.alu_fault_i;
  assign exhausted = inc && (retry_q == MAX_R);
  assign retire    = (state_q == RESP) && bus.rsp_ready_i;

  assign bus.alu_enable_o = (state_q == EXEC);
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.req_ready_o  = retire;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_cmp_o    = cmp_q;
  assign bus.rsp_error_o  = error_q;
  assign bus.perm_fault_o = perm_q;
  assign bus.fault_cnt_o  = cnt_q;
  assign bus.fault_irq_o  = irq_q;

  // Next-state selection; a faulty sample replays through one RETRY bubble unless the budget is spent
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid_i) state_d = EXEC;
      EXEC: begin
        if (sample) begin
          if (!bus.alu_fault_i || exhausted) state_d = RESP;
          else                                state_d = RETRY;
        end
      end
      RETRY:   state_d = EXEC;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, retry budget, response registers and sticky permanent-fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      retry_q  <= 3'd0;
      result_q <= 32'd0;
      cmp_q    <= 1'b0;
      error_q  <= 1'b0;
      perm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (inc && !exhausted) retry_q <= retry_q + 3'd1;
      else if (retire)       retry_q <= 3'd0;
      // Every sample overwrites the response; the last one before RESP is what EX sees
      if (sample) begin
        result_q <= bus.alu_result_i;
        cmp_q    <= bus.alu_cmp_i;
        error_q  <= exhausted;
      end
      if (exhausted) perm_q <= 1'b1;
    end
  end

  // Saturating fault counter; a clear coinciding with a fault still records that fault
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt_i)              cnt_d = inc ? CNT_W'(1) : '0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register and threshold pulse, raised only on the step onto IRQ_THRESH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= (cnt_d == IRQ_VAL) && (cnt_q != IRQ_VAL);
    end
  end

endmodule

// File: tb/tb_cv32e40p_alu_retry_ctrl.sv
// tb/tb_cv32e40p_alu_retry_ctrl.sv - scoreboard bench for the ALU retry controller
module tb_cv32e40p_alu_retry_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv32e40p_alu_retry_ctrl_if #(.CNT_W(8)) b8 ();
  cv32e40p_alu_retry_ctrl_if #(.CNT_W(4)) b4 ();

  cv32e40p_alu_retry_ctrl #(.MAX_RETRY(2), .CNT_W(8), .IRQ_THRESH(16)) dut (
    .clk(clk), .rst(rst), .bus(b8.slave));
  cv32e40p_alu_retry_ctrl #(.MAX_RETRY(2), .CNT_W(4), .IRQ_THRESH(8)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_pulses = 0;
  int irq8 = 0;
  int irq4 = 0;

  // ALU model controls
  logic [31:0] op_res = '0;
  logic        op_cmp = 1'b0;
  logic [7:0]  op_pat = '0;
  int          op_lat = 0;
  int          op_id = 0;
  logic        clr_arm = 1'b0;
  logic        clr_manual = 1'b0;
  logic        alu_ready_m = 1'b0;
  logic        alu_fault_m = 1'b0;
  logic        clr_model = 1'b0;
  int          seen_id = 0;
  int          attempt = 0;
  int          wait_cnt = 0;
  int          en_cycles = 0;

  logic [33:0] sb_q[$];
  logic [33:0] e;

  assign b8.alu_ready_i  = alu_ready_m;
  assign b8.alu_fault_i  = alu_fault_m;
  assign b8.alu_result_i = op_res;
  assign b8.alu_cmp_i    = op_cmp;
  assign b8.clr_cnt_i    = clr_model | clr_manual;

  assign b4.req_valid_i  = b8.req_valid_i;
  assign b4.rsp_ready_i  = b8.rsp_ready_i;
  assign b4.alu_ready_i  = b8.alu_ready_i;
  assign b4.alu_fault_i  = b8.alu_fault_i;
  assign b4.alu_result_i = b8.alu_result_i;
  assign b4.alu_cmp_i    = b8.alu_cmp_i;
  assign b4.clr_cnt_i    = b8.clr_cnt_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Hardened ALU model: ready after op_lat wait cycles per attempt, fault from op_pat per attempt
  always @(negedge clk) begin
    clr_model = 1'b0;
    if (rst) begin
      alu_ready_m = 1'b0;
      alu_fault_m = 1'b0;
    end else begin
      if (op_id != seen_id) begin
        seen_id = op_id; attempt = 0; wait_cnt = 0; en_cycles = 0;
      end
      if (b8.alu_enable_o) begin
        en_cycles++;
        if (wait_cnt >= op_lat) begin
          alu_ready_m = 1'b1;
          alu_fault_m = op_pat[attempt];
          if (clr_arm && alu_fault_m) clr_model = 1'b1;
          attempt++;
          wait_cnt = 0;
        end else begin
          alu_ready_m = 1'b0;
          alu_fault_m = 1'b0;
          wait_cnt++;
        end
      end else begin
        alu_ready_m = 1'b0;
        alu_fault_m = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted response, tracks retire and irq pulses
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (b8.req_ready_o) rr_pulses++;
      if (b8.rsp_valid_o && b8.rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: response accepted with no expected entry");
        end else begin
          e = sb_q.pop_front();
          chk("rsp_result", b8.rsp_result_o, e[31:0]);
          chk("rsp_cmp", 32'(b8.rsp_cmp_o), 32'(e[32]));
          chk("rsp_error", 32'(b8.rsp_error_o), 32'(e[33]));
          chk("req_ready", 32'(b8.req_ready_o), 32'd1);
        end
      end
      if (b8.fault_irq_o) begin
        irq8++;
        chk("irq8_at_cnt", 32'(b8.fault_cnt_o), 32'd16);
      end
      if (b4.fault_irq_o) begin
        irq4++;
        chk("irq4_at_cnt", 32'(b4.fault_cnt_o), 32'd8);
      end
    end
  end

  task automatic do_op(input logic [31:0] res, input logic cmp, input logic [7:0] pat,
                       input int lat, input int delay, input int exp_lat, input logic exp_err);
    int c0;
    int n;
    @(negedge clk);
    op_res = res; op_cmp = cmp; op_pat = pat; op_lat = lat; op_id++;
    sb_q.push_back({exp_err, cmp, res});
    b8.req_valid_i = 1'b1;
    c0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b8.rsp_valid_o && n < 500);
    if (!b8.rsp_valid_o) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no rsp_valid_o after %0d cycles", n);
    end
    chk("latency", 32'(cyc - c0), 32'(exp_lat));
    for (int i = 0; i < delay; i++) begin
      chk("stall_valid", 32'(b8.rsp_valid_o), 32'd1);
      chk("stall_result", b8.rsp_result_o, res);
      chk("stall_error", 32'(b8.rsp_error_o), 32'(exp_err));
      @(negedge clk);
    end
    b8.rsp_ready_i = 1'b1;
    @(negedge clk);
    b8.rsp_ready_i = 1'b0;
    b8.req_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_req_ready"}, 32'(b8.req_ready_o), 32'd0);
    chk({nm, "_alu_enable"}, 32'(b8.alu_enable_o), 32'd0);
    chk({nm, "_rsp_valid"}, 32'(b8.rsp_valid_o), 32'd0);
    chk({nm, "_rsp_result"}, b8.rsp_result_o, 32'd0);
    chk({nm, "_rsp_error"}, 32'(b8.rsp_error_o), 32'd0);
    chk({nm, "_fault_cnt"}, 32'(b8.fault_cnt_o), 32'd0);
    chk({nm, "_fault_irq"}, 32'(b8.fault_irq_o), 32'd0);
    chk({nm, "_perm_fault"}, 32'(b8.perm_fault_o), 32'd0);
    chk({nm, "_fault_cnt4"}, 32'(b4.fault_cnt_o), 32'd0);
  endtask

  initial begin
    int rr0;
    b8.req_valid_i = 1'b0;
    b8.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // T1 no fault
    do_op(32'h1234_5678, 1'b1, 8'b000, 0, 0, 2, 1'b0);
    chk("t1_fault_cnt", 32'(b8.fault_cnt_o), 32'd0);

    // T2 transient fault, one replay
    do_op(32'hA5A5_A5A5, 1'b0, 8'b001, 0, 0, 4, 1'b0);
    chk("t2_fault_cnt", 32'(b8.fault_cnt_o), 32'd1);
    chk("t2_perm", 32'(b8.perm_fault_o), 32'd0);

    // T3 permanent fault: three faulty samples
    do_op(32'hDEAD_BEEF, 1'b1, 8'b111, 0, 0, 6, 1'b1);
    chk("t3_fault_cnt", 32'(b8.fault_cnt_o), 32'd4);
    chk("t3_perm", 32'(b8.perm_fault_o), 32'd1);
    do_op(32'h0000_0042, 1'b0, 8'b000, 0, 0, 2, 1'b0);
    chk("t3_perm_sticky", 32'(b8.perm_fault_o), 32'd1);

    // T4 multicycle op with response backpressure
    rr0 = rr_pulses;
    do_op(32'h5555_AAAA, 1'b1, 8'b000, 10, 5, 12, 1'b0);
    chk("t4_enable_cycles", 32'(en_cycles), 32'd11);
    chk("t4_req_ready_pulses", 32'(rr_pulses - rr0), 32'd1);
    chk("t4_fault_cnt", 32'(b8.fault_cnt_o), 32'd4);

    // T5 counter: 4 -> 16 with one irq; small counter crosses 8 and saturates
    repeat (4) do_op(32'h0000_0016, 1'b0, 8'b111, 0, 0, 6, 1'b1);
    chk("t5_cnt16", 32'(b8.fault_cnt_o), 32'd16);
    chk("t5_irq8_once", 32'(irq8), 32'd1);
    do_op(32'h0000_0019, 1'b0, 8'b111, 0, 0, 6, 1'b1);
    do_op(32'h0000_0020, 1'b1, 8'b001, 0, 0, 4, 1'b0);
    chk("t5_cnt20", 32'(b8.fault_cnt_o), 32'd20);
    chk("t5_cnt4_sat", 32'(b4.fault_cnt_o), 32'd15);
    chk("t5_irq8_no_repeat", 32'(irq8), 32'd1);
    chk("t5_irq4_once", 32'(irq4), 32'd1);
    clr_arm = 1'b1;
    do_op(32'h0000_00C1, 1'b0, 8'b001, 0, 0, 4, 1'b0);
    clr_arm = 1'b0;
    chk("t5_clr_with_fault", 32'(b8.fault_cnt_o), 32'd1);
    chk("t5_clr_with_fault4", 32'(b4.fault_cnt_o), 32'd1);
    clr_manual = 1'b1;
    @(negedge clk);
    clr_manual = 1'b0;
    @(negedge clk);
    chk("t5_clr_plain", 32'(b8.fault_cnt_o), 32'd0);

    // T6 reset during a multicycle EXEC
    op_res = 32'hFFFF_0000; op_pat = 8'b000; op_lat = 20; op_id++;
    b8.req_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_in_exec", 32'(b8.alu_enable_o), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("t6_async");
    @(negedge clk);
    b8.req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'h0BAD_F00D, 1'b1, 8'b000, 0, 0, 2, 1'b0);
    chk("t6_perm_after", 32'(b8.perm_fault_o), 32'd0);
    chk("t6_cnt_after", 32'(b8.fault_cnt_o), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
